// File: rtl/lfsr_range_rng.sv
// -----------------------------------------------------------------------------
// lfsr_range_rng
//
// Purpose:
//   Random value source for game logic (spawn points, piece selection, ...).
//   A Galois LFSR runs freely on every clock. On request, the FSM takes the low
//   OUT_W bits of the current LFSR state as a sample. Samples in [0, RANGE-1]
//   are accepted. Samples outside that range are rejected and the next LFSR
//   state is tried. This rejection keeps the accepted values uniform.
//   After MAX_TRIES rejected samples the FSM gives up and presents FALLBACK,
//   with 'forced' raised, so a request always completes in bounded time.
//   The consumer takes the result over a valid/ready handshake.
//
// Parameters:
//   LFSR_W    LFSR state width (>= OUT_W)
//   TAPS      Galois feedback mask, applied when the shifted-out bit is 1
//   SEED      reset / default seed, must be nonzero
//   OUT_W     output value width
//   RANGE     number of accepted values, 1 <= RANGE <= 2**OUT_W
//   MAX_TRIES rejected samples allowed before FALLBACK is forced (>= 1)
//   FALLBACK  value presented on forced completion, must be < RANGE
//
// Ports:
//   clk        in   1       clock
//   reset      in   1       asynchronous, active-high reset
//   seed_load  in   1       load seed_in into the LFSR and abort any request
//   seed_in    in   LFSR_W  new seed; zero selects SEED
//   req        in   1       request one value (level)
//   out        out  OUT_W   random value, stable while out_valid is high
//   out_valid  out  1       out holds an unconsumed value
//   out_ready  in   1       consumer accepts out when out_valid is high
//   forced     out  1       out is FALLBACK because the try budget ran out
//   busy       out  1       FSM is searching for an acceptable sample
// -----------------------------------------------------------------------------
module lfsr_range_rng #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h600D,
    parameter int                OUT_W     = 3,
    parameter int                RANGE     = 6,
    parameter int                MAX_TRIES = 8,
    parameter int                FALLBACK  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              forced,
    output logic              busy
);

    // One extra bit allows RANGE == 2**OUT_W to be represented.
    localparam logic [OUT_W:0]   RANGE_EXT  = (OUT_W+1)'(RANGE);
    localparam int               TRIES_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
    localparam logic [OUT_W-1:0] FALLBACK_V = OUT_W'(FALLBACK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [LFSR_W-1:0]   lfsr, lfsr_step;
    logic [TRIES_W-1:0]  tries, tries_next;
    logic [OUT_W-1:0]    out_next;
    logic                valid_next, forced_next;
    logic [OUT_W-1:0]    sample;
    logic                sample_ok;

    assign sample    = lfsr[OUT_W-1:0];
    assign sample_ok = ({1'b0, sample} < RANGE_EXT);
    assign busy      = (state == SEARCH);

    // Galois step. The all-zero state would lock the register forever, so it
    // is steered back to SEED instead.
    always_comb begin
        lfsr_step = lfsr >> 1;
        if (lfsr == '0) begin
            lfsr_step = SEED;
        end else if (lfsr[0]) begin
            lfsr_step = (lfsr >> 1) ^ TAPS;
        end
    end

    // The LFSR runs on every edge, independent of the FSM. A reseed
    // overrides the step. A zero seed falls back to SEED so the register
    // never starts in the lockup state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr <= lfsr_step;
        end
    end

    // State, try counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tries     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            forced    <= 1'b0;
        end else begin
            state     <= state_next;
            tries     <= tries_next;
            out       <= out_next;
            out_valid <= valid_next;
            forced    <= forced_next;
        end
    end

    // Next-state logic. A reseed wins over everything and drops any request
    // in flight, but 'out' keeps its last value. In HOLD, a completed transfer
    // with req still high goes straight back to SEARCH, so back-to-back
    // requests need no IDLE cycle.
    always_comb begin
        state_next  = state;
        tries_next  = tries;
        out_next    = out;
        valid_next  = out_valid;
        forced_next = forced;

        if (seed_load) begin
            state_next  = IDLE;
            valid_next  = 1'b0;
            forced_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_next = SEARCH;
                        tries_next = '0;
                    end
                end
                SEARCH: begin
                    if (sample_ok) begin
                        out_next    = sample;
                        forced_next = 1'b0;
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end else if (tries == LAST_TRY) begin
                        out_next    = FALLBACK_V;
                        forced_next = 1'b1;
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end else begin
                        tries_next = tries + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        valid_next = 1'b0;
                        if (req) begin
                            state_next = SEARCH;
                            tries_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_range_rng
//
// Purpose:
//   Self-checking bench for lfsr_range_rng.
//   The main instance uses the default parameters. A second instance with
//   RANGE=1 and MAX_TRIES=2 exercises the forced FALLBACK path.
//   The bench pushes the expected value of each transfer into a queue. A
//   monitor pops from that queue and compares whenever out_valid and
//   out_ready are both high. All other expectations are written directly
//   in the test sequence.
// -----------------------------------------------------------------------------
module tb_lfsr_range_rng;

    localparam logic [15:0] SEED = 16'h600D;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam int          N_REQ = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [2:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        forced;
    logic        busy;

    logic        r1_req;
    logic        r1_seed_load;
    logic [15:0] r1_seed_in;
    logic [2:0]  r1_out;
    logic        r1_valid;
    logic        r1_ready;
    logic        r1_forced;
    logic        r1_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] value;
        logic       forced;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_exp;
    int          seen[8];
    logic [15:0] model_lfsr;

    always #5 clk = ~clk;

    lfsr_range_rng dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .forced    (forced),
        .busy      (busy)
    );

    lfsr_range_rng #(.RANGE(1), .MAX_TRIES(2), .FALLBACK(0)) dut_r1 (
        .clk       (clk),
        .reset     (reset),
        .seed_load (r1_seed_load),
        .seed_in   (r1_seed_in),
        .req       (r1_req),
        .out       (r1_out),
        .out_valid (r1_valid),
        .out_ready (r1_ready),
        .forced    (r1_forced),
        .busy      (r1_busy)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        if (s == 16'h0)
            return SEED;
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Reference LFSR that tracks the main instance, so the bench knows which
    // state a future sample edge will see.
    always @(posedge clk or posedge reset) begin
        if (reset)
            model_lfsr <= SEED;
        else if (seed_load)
            model_lfsr <= (seed_in == 16'h0) ? SEED : seed_in;
        else
            model_lfsr <= lfsrStep(model_lfsr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic sl,
                                 input logic [15:0] si);
        req       = r;
        out_ready = rdy;
        seed_load = sl;
        seed_in   = si;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the handshake is sampled on the falling edge. The transfer
    // itself happens on the following rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            seen[out] = seen[out] + 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_xfer: got value %0d, expected no transfer", out);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("xfer_value", {29'd0, out}, {29'd0, mon_exp.value});
                checkOutput("xfer_forced", {31'd0, forced}, {31'd0, mon_exp.forced});
            end
        end
    end

    initial begin
        logic [15:0] s;
        logic [15:0] p;
        logic [2:0]  last_val;
        logic [7:0]  seen_mask;
        exp_t        e;
        int          tries;
        int          xfers;
        int          cyc;
        int          steps;
        int          zero_seen;
        int          mism;

        for (int i = 0; i < 8; i++) seen[i] = 0;
        reset        = 1'b1;
        r1_req       = 1'b0;
        r1_seed_load = 1'b0;
        r1_seed_in   = 16'h0;
        r1_ready     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        last_val = 3'd0;

        // Reset values
        #1;
        checkOutput("rst_out", {29'd0, out}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_forced", {31'd0, forced}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});

        // T1: req is sampled at edge 1 (lfsr=600D). Sample 6 is rejected at
        // edge 2. Sample 3 is accepted at edge 3.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        exp_q.push_back('{value: 3'd3, forced: 1'b0});
        #1 reset = 1'b0;
        tick;
        checkOutput("t1_busy_e1", {31'd0, busy}, 32'd1);
        checkOutput("t1_lfsr_e1", {16'd0, dut.lfsr}, 32'h8406);
        tick;
        checkOutput("t1_valid_e2", {31'd0, out_valid}, 32'd0);
        checkOutput("t1_busy_e2", {31'd0, busy}, 32'd1);
        tick;
        checkOutput("t1_valid_e3", {31'd0, out_valid}, 32'd1);
        checkOutput("t1_out_e3", {29'd0, out}, 32'd3);
        checkOutput("t1_forced_e3", {31'd0, forced}, 32'd0);
        checkOutput("t1_busy_e3", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput("t1_hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("t1_hold_out", {29'd0, out}, 32'd3);
        end

        // T2: back-to-back requests. The transfer of 3 happens at the next
        // edge, so the first new sample sees the state one step after the
        // current one. After each completion, the next sample sees the state
        // two steps later.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        s = lfsrStep(model_lfsr);
        for (int n = 0; n < N_REQ; n++) begin
            tries = 0;
            while (1) begin
                if (s[2:0] < 3'd6) begin
                    e.value = s[2:0];
                    e.forced = 1'b0;
                    break;
                end else if (tries == 7) begin
                    e.value = 3'd0;
                    e.forced = 1'b1;
                    break;
                end
                tries++;
                s = lfsrStep(s);
            end
            exp_q.push_back(e);
            last_val = e.value;
            s = lfsrStep(lfsrStep(s));
        end
        xfers = 1;
        cyc = 0;
        while (xfers < N_REQ + 1 && cyc < 40000) begin
            tick;
            cyc++;
            if (out_valid && out_ready) begin
                xfers++;
                if (xfers == N_REQ + 1)
                    req = 1'b0;
            end
        end
        checkOutput("t2_xfer_count", xfers, N_REQ + 1);
        tick;
        checkOutput("t2_queue_empty", exp_q.size(), 32'd0);
        checkOutput("t2_idle_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t2_idle_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) seen_mask[i] = (seen[i] > 0);
        checkOutput("t2_value_set", {24'd0, seen_mask}, 32'h3F);

        // T4: a reseed during SEARCH aborts the request.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        tick;
        checkOutput("t4_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        tick;
        checkOutput("t4_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t4_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("t4_lfsr_default", {16'd0, dut.lfsr}, {16'd0, SEED});
        checkOutput("t4_out_kept", {29'd0, out}, {29'd0, last_val});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hACE1);
        tick;
        checkOutput("t4_lfsr_ace1", {16'd0, dut.lfsr}, 32'hACE1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

        // T5: an asynchronous reset in the middle of HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        checkOutput("t5_reach_hold", {31'd0, out_valid}, 32'd1);
        req = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        r1_req = 1'b1;
        #1;
        checkOutput("t5_out", {29'd0, out}, 32'd0);
        checkOutput("t5_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_forced", {31'd0, forced}, 32'd0);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});

        // T3: RANGE=1, MAX_TRIES=2 from 600D. The samples 6 and 3 are both
        // rejected, so FALLBACK is forced on the second sample edge.
        #2 reset = 1'b0;
        tick;
        checkOutput("t3_busy_e1", {31'd0, r1_busy}, 32'd1);
        tick;
        checkOutput("t3_valid_e2", {31'd0, r1_valid}, 32'd0);
        checkOutput("t3_busy_e2", {31'd0, r1_busy}, 32'd1);
        tick;
        checkOutput("t3_valid_e3", {31'd0, r1_valid}, 32'd1);
        checkOutput("t3_out_e3", {29'd0, r1_out}, 32'd0);
        checkOutput("t3_forced_e3", {31'd0, r1_forced}, 32'd1);
        checkOutput("t3_main_idle", {31'd0, out_valid}, 32'd0);
        r1_req = 1'b0;

        // T6: recovery from the lockup state, then the full period.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        force dut.lfsr = 16'h0;
        #1 release dut.lfsr;
        checkOutput("t6_forced_zero", {16'd0, dut.lfsr}, 32'd0);
        tick;
        checkOutput("t6_recover", {16'd0, dut.lfsr}, {16'd0, SEED});
        p = SEED;
        steps = 0;
        zero_seen = 0;
        mism = 0;
        do begin
            tick;
            p = lfsrStep(p);
            steps++;
            if (dut.lfsr == 16'h0) zero_seen++;
            if (dut.lfsr != p) mism++;
        end while (dut.lfsr != SEED && steps < 70000);
        checkOutput("t6_period", steps, 32'd65535);
        checkOutput("t6_zero_states", zero_seen, 32'd0);
        checkOutput("t6_sequence", mism, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
